// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encoding, memory timing
// and access widths.
package mem_arbiter_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam int MEM_RD_LATENCY = 1;
    localparam int BE_W           = 4;
    localparam int DATA_W         = 32;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data: data is preferred unless the
// streak limit has been reached while fetch is waiting.
module mem_arb_pick (
    input  logic iss_i,
    input  logic iss_d,
    input  logic streak_hit,
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_d = iss_d & (~iss_i | ~streak_hit);
        grant_i = iss_i & (~iss_d | streak_hit);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch and
// data ports; one access per cycle, result returned the following cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [BE_W-1:0]   d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic [BE_W-1:0]   m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [15:0]       conflict_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] streak;
    logic       iss_i;
    logic       iss_d;
    logic       streak_hit;
    logic       grant_i;
    logic       grant_d;

    // Valid/ready: a port's req stays high and stable until its one-cycle
    // ready pulse; req seen during that pulse belongs to the retiring request.
    assign i_ready = (state == BUSY_I);
    assign d_ready = (state == BUSY_D);
    assign i_rdata = i_ready ? m_rdata : '0;
    assign d_rdata = d_ready ? m_rdata : '0;

    // rst gates issue so the memory stays quiet for the whole reset window.
    assign iss_i      = rst & i_req & ~i_ready;
    assign iss_d      = rst & d_req & ~d_ready;
    assign streak_hit = (streak >= STREAK_LIM);
    assign dbg_state  = state;

    mem_arb_pick u_pick (
        .iss_i      (iss_i),
        .iss_d      (iss_d),
        .streak_hit (streak_hit),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_comb begin
        state_nxt = IDLE;
        m_en      = 1'b0;
        m_wen     = '0;
        m_addr    = '0;
        m_wdata   = '0;
        if (grant_d) begin
            state_nxt = BUSY_D;
            m_en      = 1'b1;
            m_wen     = d_wen;
            m_addr    = d_addr;
            m_wdata   = d_wdata;
        end else if (grant_i) begin
            state_nxt = BUSY_I;
            m_en      = 1'b1;
            m_addr    = i_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            streak       <= '0;
            conflict_cnt <= '0;
        end else begin
            state <= state_nxt;
            // The streak only measures how long a waiting fetch has been passed over.
            if (grant_i || !i_req) begin
                streak <= '0;
            end else if (grant_d && (streak < STREAK_LIM)) begin
                streak <= streak + 4'd1;
            end
            if (iss_i && iss_d && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and a
// cycle-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int STREAK_MAX = 4;
    localparam int MEM_WORDS  = 128;

    typedef struct packed {
        logic        i_ready;
        logic        d_ready;
        logic        m_en;
        logic [3:0]  m_wen;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [15:0] conflict;
    } cyc_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ready;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic [3:0]        d_wen = '0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              m_en;
    logic [3:0]        m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata = '0;
    logic [15:0]       conflict_cnt;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .STREAK_MAX(STREAK_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .conflict_cnt(conflict_cnt), .dbg_state(dbg_state)
    );

    // Memory behind the arbiter: synchronous read, byte-write enables.
    logic [31:0] mem [MEM_WORDS];
    always @(posedge clk) begin
        if (m_en) begin
            m_rdata <= mem[m_addr[8:2]];
            for (int b = 0; b < BE_W; b++) begin
                if (m_wen[b]) mem[m_addr[8:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    cyc_t        exp_q[$];
    logic [31:0] exp_i_q[$];
    logic [32:0] exp_d_q[$];   // bit 32 set: write, rdata not checked

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [MEM_WORDS];
    int served_q[$];   // owner of each issue, delivered MEM_RD_LATENCY cycles later
    int streak;
    int conflicts;
    int n_grant_i;
    int n_grant_d;

    function automatic int widx(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
    endfunction

    task automatic model_reset();
        streak    = 0;
        conflicts = 0;
        served_q.delete();
        for (int k = 0; k < MEM_RD_LATENCY; k++) served_q.push_back(0);
        exp_q.delete();
        exp_i_q.delete();
        exp_d_q.delete();
    endtask

    // ---------------- driver ----------------
    int p_i = 0, p_d = 0, p_w = 0, p_drop = 0;
    bit i_out = 1'b0, d_out = 1'b0;
    bit i_dir = 1'b0, d_dir = 1'b0;
    logic [31:0] i_dir_addr, d_dir_addr, d_dir_wdata;
    logic [3:0]  d_dir_wen;

    // Called just after a rising edge: drive this cycle's inputs, then push
    // what the arbitration rules say the DUT must show in this cycle.
    task automatic step();
        int comp;
        int win;
        bit iss_i, iss_d;
        cyc_t e;
        comp = served_q.pop_front();

        if (comp == 1) begin
            if ($urandom_range(0, 99) < p_drop) i_req = 1'b0;
            i_out = 1'b0;
        end else if (!i_out) begin
            if (i_dir) begin
                i_req = 1'b1; i_addr = i_dir_addr; i_out = 1'b1; i_dir = 1'b0;
            end else if ($urandom_range(0, 99) < p_i) begin
                i_req = 1'b1; i_addr = rand_addr(); i_out = 1'b1;
            end else begin
                i_req = 1'b0;
            end
        end

        if (comp == 2) begin
            if ($urandom_range(0, 99) < p_drop) d_req = 1'b0;
            d_out = 1'b0;
        end else if (!d_out) begin
            if (d_dir) begin
                d_req = 1'b1; d_addr = d_dir_addr; d_wen = d_dir_wen;
                d_wdata = d_dir_wdata; d_out = 1'b1; d_dir = 1'b0;
            end else if ($urandom_range(0, 99) < p_d) begin
                d_req   = 1'b1;
                d_addr  = rand_addr();
                d_wen   = ($urandom_range(0, 99) < p_w) ? 4'($urandom_range(1, 15)) : 4'd0;
                d_wdata = $urandom();
                d_out   = 1'b1;
            end else begin
                d_req = 1'b0;
            end
        end

        iss_i = i_req && (comp != 1);
        iss_d = d_req && (comp != 2);
        if (iss_i && iss_d) win = (streak < STREAK_MAX) ? 2 : 1;
        else if (iss_d)     win = 2;
        else if (iss_i)     win = 1;
        else                win = 0;

        e = '0;
        e.i_ready  = (comp == 1);
        e.d_ready  = (comp == 2);
        e.conflict = 16'(conflicts);
        if (win == 1) begin
            e.m_en   = 1'b1;
            e.m_addr = i_addr;
            exp_i_q.push_back(ref_mem[widx(i_addr)]);
            n_grant_i++;
        end else if (win == 2) begin
            e.m_en    = 1'b1;
            e.m_addr  = d_addr;
            e.m_wen   = d_wen;
            e.m_wdata = d_wdata;
            exp_d_q.push_back({d_wen != 4'd0, ref_mem[widx(d_addr)]});
            for (int b = 0; b < BE_W; b++) begin
                if (d_wen[b]) ref_mem[widx(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
            end
            n_grant_d++;
        end
        exp_q.push_back(e);

        if (iss_i && iss_d && conflicts < 65535) conflicts++;
        if (win == 1 || !i_req) streak = 0;
        else if (win == 2 && streak < STREAK_MAX) streak++;
        served_q.push_back(win);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            step();
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc_t e;
        logic [32:0] dv;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("i_ready", 32'(i_ready), 32'(e.i_ready));
            check("d_ready", 32'(d_ready), 32'(e.d_ready));
            check("m_en", 32'(m_en), 32'(e.m_en));
            check("m_wen", 32'(m_wen), 32'(e.m_wen));
            check("m_addr", m_addr, e.m_addr);
            check("m_wdata", m_wdata, e.m_wdata);
            check("conflict_cnt", 32'(conflict_cnt), 32'(e.conflict));
            if (i_ready) begin
                if (exp_i_q.size() == 0) check("i_ready_unexpected", 32'(1), 32'(0));
                else check("i_rdata", i_rdata, exp_i_q.pop_front());
            end
            if (d_ready) begin
                if (exp_d_q.size() == 0) begin
                    check("d_ready_unexpected", 32'(1), 32'(0));
                end else begin
                    dv = exp_d_q.pop_front();
                    if (!dv[32]) check("d_rdata", d_rdata, dv[31:0]);
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_i_ready"}, 32'(i_ready), 32'(0));
        check({tag, "_d_ready"}, 32'(d_ready), 32'(0));
        check({tag, "_m_en"}, 32'(m_en), 32'(0));
        check({tag, "_m_wen"}, 32'(m_wen), 32'(0));
        check({tag, "_m_addr"}, m_addr, 32'(0));
        check({tag, "_m_wdata"}, m_wdata, 32'(0));
        check({tag, "_i_rdata"}, i_rdata, 32'(0));
        check({tag, "_d_rdata"}, d_rdata, 32'(0));
        check({tag, "_conflict"}, 32'(conflict_cnt), 32'(0));
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < MEM_WORDS; k++) begin
            mem[k]     = 32'(k) * 32'h01010101 ^ 32'hA5C3_0F96;
            ref_mem[k] = 32'(k) * 32'h01010101 ^ 32'hA5C3_0F96;
        end
        mem[16]     = 32'h2402000A;
        ref_mem[16] = 32'h2402000A;
        n_grant_i = 0;
        n_grant_d = 0;

        // Reset held with both ports requesting: nothing may reach the memory.
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h80;
        repeat (3) @(negedge clk) check_quiet("reset");

        // Release: data must be served first, in the very first cycle.
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        i_out = 1'b1;
        d_out = 1'b1;
        step();
        run(5);

        // Lone fetch of the known word at 0x40.
        i_dir = 1'b1; i_dir_addr = 32'h40;
        run(4);

        // Continuous contention: owners must alternate D,I,D,I.
        p_i = 100; p_d = 100; p_w = 0; p_drop = 0;
        run(24);
        p_i = 0; p_d = 0;
        run(4);

        // Partial store, then read back to see the merged word.
        d_dir = 1'b1; d_dir_addr = 32'h100; d_dir_wen = 4'b0011; d_dir_wdata = 32'hDEADBEEF;
        run(3);
        d_dir = 1'b1; d_dir_addr = 32'h100; d_dir_wen = 4'b0000; d_dir_wdata = 32'h0;
        run(3);

        // Mixed random traffic, including req dropped during the ready cycle.
        p_i = 60; p_d = 60; p_w = 30; p_drop = 50;
        run(400);
        p_i = 0; p_d = 0; p_drop = 0;
        run(4);

        // Reset while a data access is in flight.
        d_dir = 1'b1; d_dir_addr = 32'h44; d_dir_wen = 4'b0000; d_dir_wdata = 32'h0;
        run(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; i_out = 1'b0; d_out = 1'b0;
        #1;
        check_quiet("midreset");
        repeat (2) @(negedge clk) check_quiet("midreset_hold");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step();
        run(4);
        @(negedge clk);
        check("drain_i", 32'(exp_i_q.size()), 32'(0));
        check("drain_d", 32'(exp_d_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
